// File: rtl/score_display.sv
// Binary score (tenths of a second) to 5-digit BCD via iterative double-dabble,
// shown on a multiplexed active-low 7-segment display with leading-zero blanking.
module score_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_ANODES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           score,
  output logic                  busy,
  output logic [19:0]           bcd_out,
  output logic [NUM_ANODES-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_ANODES > 1) ? $clog2(NUM_ANODES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg;
  logic [15:0]     src_reg;
  logic [15:0]     cap_reg;
  logic [15:0]     src_done_reg;
  logic [19:0]     bcd_reg;
  logic [19:0]     bcd_adj;
  logic [3:0]      count_reg;
  logic            busy_reg;
  logic [19:0]     bcd_out_reg;

  logic [RW-1:0]   refresh_reg;
  logic [IW-1:0]   idx_reg;

  logic [NUM_ANODES-1:0] an_reg, an_next;
  logic [6:0]      seg_reg, seg_next;
  logic            dp_reg, dp_next;

  logic [3:0]      digit [5];
  logic [4:0]      blank;
  logic [3:0]      sel_digit;
  logic            sel_lit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'b1000000;
      4'd1: decode = 7'b1111001;
      4'd2: decode = 7'b0100100;
      4'd3: decode = 7'b0110000;
      4'd4: decode = 7'b0011001;
      4'd5: decode = 7'b0010010;
      4'd6: decode = 7'b0000010;
      4'd7: decode = 7'b1111000;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Add-3 correction on every nibble before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      assign digit[gi] = bcd_out_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      src_reg      <= '0;
      cap_reg      <= '0;
      src_done_reg <= '0;
      bcd_reg      <= '0;
      count_reg    <= '0;
      busy_reg     <= 1'b0;
      bcd_out_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (score != src_done_reg) begin
            src_reg   <= score;
            cap_reg   <= score;
            bcd_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_reg, src_reg} <= {bcd_adj, src_reg} << 1;
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd15) state_reg <= DONE;
        end
        DONE: begin
          bcd_out_reg  <= bcd_reg;
          src_done_reg <= cap_reg;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_reg <= '0;
      idx_reg     <= '0;
    end else if (refresh_reg == RW'(REFRESH_DIV - 1)) begin
      refresh_reg <= '0;
      idx_reg     <= (idx_reg == IW'(NUM_ANODES - 1)) ? '0 : idx_reg + IW'(1);
    end else begin
      refresh_reg <= refresh_reg + RW'(1);
    end
  end

  // A slot from 2 up blanks when it and every higher digit are zero.
  assign blank[4]   = (digit[4] == 4'd0);
  generate
    for (gi = 2; gi < 4; gi++) begin : g_blank
      assign blank[gi] = blank[gi+1] && (digit[gi] == 4'd0);
    end
  endgenerate
  assign blank[1:0] = 2'b00;

  always_comb begin
    an_next   = '1;
    seg_next  = 7'h7F;
    dp_next   = 1'b1;
    sel_digit = 4'd0;
    sel_lit   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (int'(idx_reg) == k) begin
        sel_digit = digit[k];
        sel_lit   = !blank[k];
      end
    end
    if (sel_lit) begin
      an_next  = ~(NUM_ANODES'(1) << idx_reg);
      seg_next = decode(sel_digit);
      dp_next  = (idx_reg != IW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_reg  <= '1;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign busy    = busy_reg;
  assign bcd_out = bcd_out_reg;
  assign an      = an_reg;
  assign seg     = seg_reg;
  assign dp      = dp_reg;

endmodule

// File: tb/tb_score_display.sv
// Randomized and directed bench for score_display: a scoreboard queue of
// expected conversions checked on each busy falling edge, plus display scans.
module tb_score_display;

  localparam int NA = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   score;
  logic          busy;
  logic [19:0]   bcd_out;
  logic [NA-1:0] an;
  logic [6:0]    seg;
  logic          dp;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int last_v   = 0;
  logic busy_prev = 1'b0;

  score_display #(.REFRESH_DIV(4), .NUM_ANODES(NA)) dut (
    .clk(clk), .reset(reset), .score(score), .busy(busy),
    .bcd_out(bcd_out), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[k*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    score = 16'(v);
    if (v != last_v) begin
      exp_q.push_back(v);
      last_v = v;
    end
    $display("send score=%0d queued=%0d", v, exp_q.size());
  endtask

  // Watches a full scan and checks every lit slot against the decimal value.
  task automatic check_display(input int v);
    int seen;
    int pos;
    int p;
    int want_mask;
    seen = 0;
    repeat (40) begin
      tick;
      if (an != {NA{1'b1}}) begin
        check("an_onehot", 32'($onehot(~an)), 32'd1);
        pos = 0;
        for (int k = 0; k < NA; k++) if (!an[k]) pos = k;
        p = 1;
        for (int k = 0; k < pos; k++) p = p * 10;
        check("seg_lit", {25'd0, seg}, {25'd0, seg_ref((v / p) % 10)});
        check("dp_lit", {31'd0, dp}, (pos == 1) ? 32'd0 : 32'd1);
        seen = seen | (1 << pos);
      end else begin
        check("seg_dark", {25'd0, seg}, 32'h7F);
        check("dp_dark", {31'd0, dp}, 32'd1);
      end
    end
    want_mask = 3 | ((v >= 100) ? 4 : 0) | ((v >= 1000) ? 8 : 0) | ((v >= 10000) ? 16 : 0);
    check("lit_slots", 32'(seen), 32'(want_mask));
    $display("display v=%0d lit_mask=%0h", v, seen);
  endtask

  // Scoreboard monitor: each completed conversion pops one expected value.
  always @(negedge clk) begin
    int v;
    if (reset !== 1'b1 && busy_prev === 1'b1 && busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {12'd0, bcd_out}, 32'hFFFFFFFF);
      end else begin
        v = exp_q.pop_front();
        check("scoreboard", {12'd0, bcd_out}, {12'd0, to_bcd(v)});
        $display("done bcd_out=%05h expected=%0d", bcd_out, v);
      end
    end
    busy_prev = busy;
  end

  initial begin
    int v;
    int mode;
    reset = 1'b1;
    score = 16'd0;
    repeat (3) tick;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bcd", {12'd0, bcd_out}, 32'd0);
    reset = 1'b0;
    check_display(0);

    // 12345: exact latency
    send(12345);
    tick;
    check("busy_n1", {31'd0, busy}, 32'd1);
    repeat (16) begin
      tick;
      check("busy_hold", {31'd0, busy}, 32'd1);
    end
    tick;
    check("busy_n18", {31'd0, busy}, 32'd0);
    check("bcd_12345", {12'd0, bcd_out}, 32'h12345);
    check_display(12345);

    send(65535);
    repeat (18) tick;
    check("bcd_65535", {12'd0, bcd_out}, 32'h65535);
    check_display(65535);

    send(7);
    repeat (18) tick;
    check("bcd_7", {12'd0, bcd_out}, 32'h00007);
    check_display(7);

    // change mid-conversion
    send(100);
    repeat (5) tick;
    send(200);
    repeat (13) tick;
    check("bcd_100", {12'd0, bcd_out}, 32'h00100);
    check("busy_n18b", {31'd0, busy}, 32'd0);
    tick;
    check("busy_n19", {31'd0, busy}, 32'd1);
    repeat (17) tick;
    check("bcd_200", {12'd0, bcd_out}, 32'h00200);
    check("busy_n36", {31'd0, busy}, 32'd0);

    // reset aborts conversion
    send(999);
    repeat (8) tick;
    reset = 1'b1;
    exp_q.delete();
    last_v = 0;
    repeat (2) tick;
    check("abort_bcd", {12'd0, bcd_out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    exp_q.push_back(999);
    last_v = 999;
    repeat (17) tick;
    check("rerun_busy", {31'd0, busy}, 32'd1);
    tick;
    check("bcd_999", {12'd0, bcd_out}, 32'h00999);

    // no reconversion of a held value
    repeat (100) begin
      tick;
      check("hold_busy", {31'd0, busy}, 32'd0);
      check("hold_bcd", {12'd0, bcd_out}, 32'h00999);
    end

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: v = last_v;
        1: v = $urandom_range(0, 99);
        2: v = $urandom_range(0, 65535);
        default: v = $urandom_range(100, 9999);
      endcase
      send(v);
      repeat ($urandom_range(19, 26)) tick;
      check("rand_bcd", {12'd0, bcd_out}, {12'd0, to_bcd(v)});
      if (i % 5 == 0) check_display(v);
    end

    repeat (5) tick;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
